// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, glyph table and monitor FSM states.
// All patterns here are lit-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index i holds the glyph for hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOCK = 2'd1,
    S_FILT = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational lit-high 7-bit pattern to hex digit decoder.
// Reports whether the pattern is a known glyph or fully blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       legal,
  output logic       blank,
  output logic [3:0] digit
);

  // Search the glyph table; entries are unique so at most one hits.
  always_comb begin
    legal = 1'b0;
    digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        legal = 1'b1;
        digit = 4'(i);
      end
    end
    blank = (pat == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_monitor.sv
// Glitch-filtering seven-segment bus checker with count-sequence check.
// Define SEG7_MON_SEQ_CHECK_EN to build the modulo-N sequence checker.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MOD_N         = 10,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  output logic [3:0] digit,
  output logic       dp,
  output logic       digit_valid,
  output logic       illegal,
  output logic       lock,
  output logic       seq_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  logic [7:0] seg_d, seg_q;
  logic [7:0] cnt_d, cnt_q;
  logic [7:0] acc_d, acc_q;
  state_e     state_d, state_q;
  logic [3:0] digit_d, digit_q;
  logic       dp_d, dp_q;
  logic       valid_d, valid_q;
  logic       illegal_d, illegal_q;
  logic       lock_d, lock_q;
  logic       accept;
  logic       dec_legal;
  logic       dec_blank;
  logic [3:0] dec_digit;

  // The sample entering seg_q is what gets counted, so seg_q itself is
  // the candidate: it reloads whenever the new sample differs from it.
  seg7_decode u_dec (
    .pat   (seg_d[6:0]),
    .legal (dec_legal),
    .blank (dec_blank),
    .digit (dec_digit)
  );

  // Filter counter, accept detection, FSM and decoded output updates.
  always_comb begin
    seg_d     = (ACTIVE_LOW != 0) ? ~seg : seg;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    state_d   = state_q;
    digit_d   = digit_q;
    dp_d      = dp_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    lock_d    = lock_q;
    if (seg_d != seg_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STAB) begin
      cnt_d = cnt_q + 8'd1;
    end
    accept = (cnt_d == STAB) &&
             ((state_q == S_INIT) || (seg_d != acc_q));
    if (accept) begin
      state_d = S_LOCK;
      acc_d   = seg_d;
      lock_d  = 1'b1;
      if (dec_legal) begin
        digit_d = dec_digit;
        dp_d    = seg_d[SEG_DP];
        valid_d = 1'b1;
      end else if (!dec_blank) begin
        illegal_d = 1'b1;
      end
    end else if (state_q == S_LOCK && seg_d != acc_q) begin
      state_d = S_FILT;
    end else if (state_q == S_FILT && seg_d == acc_q) begin
      state_d = S_LOCK;
    end
  end

  // Filter, FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q     <= 8'h00;
      cnt_q     <= 8'd0;
      acc_q     <= 8'h00;
      state_q   <= S_INIT;
      digit_q   <= 4'd0;
      dp_q      <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      lock_q    <= lock_d;
    end
  end

  assign digit       = digit_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign illegal     = illegal_q;
  assign lock        = lock_q;

`ifdef SEG7_MON_SEQ_CHECK_EN
  logic [3:0] prev_d, prev_q;
  logic       pvld_d, pvld_q;
  logic       serr_d, serr_q;
  logic [7:0] ecnt_d, ecnt_q;
  logic [3:0] exp_dig;
  logic       bad;

  // Compare each legal digit against the successor of the previous one;
  // blank or illegal accepts drop the reference.
  always_comb begin
    prev_d  = prev_q;
    pvld_d  = pvld_q;
    serr_d  = serr_q;
    ecnt_d  = ecnt_q;
    exp_dig = 4'((int'(prev_q) + 1) % MOD_N);
    bad     = (dec_digit != exp_dig) ||
              (int'(dec_digit) >= MOD_N);
    if (accept) begin
      if (dec_legal) begin
        if (pvld_q && bad) begin
          serr_d = 1'b1;
          if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end
        prev_d = dec_digit;
        pvld_d = 1'b1;
      end else begin
        pvld_d = 1'b0;
      end
    end
  end

  // Sequence reference and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 4'd0;
      pvld_q <= 1'b0;
      serr_q <= 1'b0;
      ecnt_q <= 8'd0;
    end else begin
      prev_q <= prev_d;
      pvld_q <= pvld_d;
      serr_q <= serr_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign seq_err = serr_q;
  assign err_cnt = ecnt_q;
`else
  assign seq_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Receive-side checker for the 8-bit seven-segment bus driven by the lab counter/display blocks. Samples `seg`, filters glitches, decodes stable patterns back to a hex digit plus decimal point, and checks that successive digits follow a modulo-N count sequence. Instantiated in simulation benches and on-board self-test next to the display driver, on the same clock.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a pattern; legal range 1..255.
- `MOD_N`, 10: count modulus for the sequence check; legal range 2..16.
- `ACTIVE_LOW`, 1: 1 means a segment is lit when its bit is 0 (common anode); 0 means lit when its bit is 1.

- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `seg`  in  8: `{dp,g,f,e,d,c,b,a}`, polarity per `ACTIVE_LOW`.
- `digit`  out  4: last accepted legal digit.
- `dp`  out  1: decimal point of the last accepted legal pattern, 1 = lit.
- `digit_valid`  out  1: one-cycle pulse when a new legal digit is accepted.
- `illegal`  out  1: one-cycle pulse when an unknown non-blank pattern is accepted.
- `lock`  out  1: high once any pattern has been accepted since reset.
- `seq_err`  out  1: sticky; set on the first sequence violation.
- `err_cnt`  out  8: count of sequence violations, saturating at 255.

## Operation
- Input register `seg_q` captures `seg` every cycle. Polarity is normalised to lit = 1 before any compare.
- Filter: `cand` holds the pattern under test; `stab_cnt` counts matching samples.
  - If `seg_q != cand`: load `cand <= seg_q` and set `stab_cnt <= 1`.
  - Otherwise increment `stab_cnt`, saturating at `STABLE_CYCLES`.
- FSM:
  - S_INIT: nothing accepted yet.
  - S_LOCK: accepted pattern `acc` is held.
  - S_FILT: `cand != acc` and is being counted.
  - INIT→LOCK, or FILT→LOCK, when `stab_cnt` reaches `STABLE_CYCLES`. This event is called "accept".
  - LOCK→FILT when `seg_q != acc`.
  - FILT→LOCK with no accept when `seg_q` returns to `acc`. No pulse is generated.
- On accept, the lower 7 bits are decoded with the standard 0-F table:
  - Legal pattern: update `digit` and `dp`, pulse `digit_valid`, set `lock`.
  - Blank (all segments off, dp ignored): set `lock`, no pulse, clear the sequence reference.
  - Other pattern: pulse `illegal`, set `lock`; `digit` is unchanged and the sequence reference is cleared.
- Sequence check:
  - The reference `prev` is valid after a legal accept.
  - On the next legal accept, the expected digit is `(prev+1) % MOD_N`.
  - A mismatch, or a digit ≥ `MOD_N`, sets `seq_err` and increments `err_cnt`.
  - `prev` always updates to the new digit.
  - The first legal digit after reset, blank or illegal is never checked.
- Re-accepting the same pattern is impossible: accept only occurs when `cand != acc`, or in S_INIT.

## Timing
- Latency: a pattern first captured into `seg_q` at edge E0 and held produces accept at edge E0+`STABLE_CYCLES`−1.
- `digit`, `dp`, `digit_valid` and `illegal` are registered and change on that same edge.
- `seq_err` and `err_cnt` update on the same edge as the offending `digit_valid`.
- With `STABLE_CYCLES`=1, every single-cycle change of `seg` is accepted.
- A glitch shorter than `STABLE_CYCLES` samples never alters any output.
- Reset (`rst`=0) asynchronously clears everything: `digit`=0, `dp`=0, `digit_valid`=0, `illegal`=0, `lock`=0, `seq_err`=0, `err_cnt`=0, FSM to S_INIT, `cand`/`acc`/`seg_q` to blank, `prev` invalid. This applies mid-filter as well.
- `err_cnt` at 255 holds at 255; `seq_err` stays 1 until reset.

## Configuration
- `SEG7_MON_SEQ_CHECK_EN` defined: the sequence checker is compiled in as described.
- Not defined: `prev` and the checker logic are absent, and `seq_err`/`err_cnt` are tied to 0.
- Filter, decode, `digit_valid` and `illegal` behave identically either way.

## Structure
- Package `seg7_pkg`:
  - 16-entry lit-high segment table for 0-F.
  - `SEG_BLANK`.
  - Bit-index constants for a..g and dp.
  - FSM state enum (S_INIT, S_LOCK, S_FILT).
- Sub-module `seg7_decode`: combinational 7-bit pattern → `{legal, blank, digit[3:0]}`. Shared with the display driver's self-check.

## Test plan
- Reset with `seg` set to the pattern for "0", then release and hold 10 cycles → one `digit_valid` at edge E0+3, `digit`=0, `lock`=1, `seq_err`=0.
- Drive 0,1,…,9,0 with each held 6 cycles → 11 `digit_valid` pulses; `seq_err`=0, `err_cnt`=0.
- Hold "3", inject "8" for 3 cycles, return to "3" → no pulse, `digit` stays 3, FSM back in S_LOCK.
- Drive 2 then 5 → `seq_err`=1, `err_cnt`=1; then drive 6 → no new error, `err_cnt` stays 1.
- Drive pattern 7'b1010101 (illegal) → `illegal` pulses once, `digit` unchanged; the following "7" is not checked.
- Assert `rst` mid-filter with `err_cnt`=4 → all outputs 0 immediately; the first digit after release is not checked.
